// File: rtl/sprite_line_sched.sv
// Per-scanline sprite scheduler: scans object RAM, fetches one tile row per hit, issues draw commands.
// Optional per-line sprite cap enabled by defining SPRITE_LIMIT_EN.
module sprite_line_sched #(
  parameter int NUM_OBJ      = 128,
  parameter int MAX_PER_LINE = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [8:0]  target_v,
  output logic [7:0]  obj_addr,
  input  logic [63:0] obj_data,
  output logic        rom_req,
  output logic [19:0] rom_addr,
  input  logic        rom_ack,
  input  logic [63:0] rom_data,
  output logic [63:0] lb_bitplanes,
  output logic        lb_flip,
  output logic [3:0]  lb_color,
  output logic [9:0]  lb_pos,
  output logic        lb_we,
  input  logic        lb_idle,
  output logic        busy,
  output logic        overflow,
  output logic [3:0]  dbg_state
);

  localparam int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_WAIT_OBJ, S_CHECK, S_FETCH, S_WAIT_LB, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [8:0]    tv_q;
  logic          abort_q;
  logic          cap_hit;

  logic [8:0]    ent_y;
  logic [1:0]    ent_h;
  logic [15:0]   ent_code;
  logic [3:0]    ent_color;
  logic          ent_fx, ent_fy;
  logic [9:0]    ent_x;

  logic [8:0]    rel;
  logic [7:0]    height;
  logic          hit;
  logic [7:0]    row8;
  logic [15:0]   code_eff;

  // rel wraps mod 512, so sprites straddling line 0 still hit
  always_comb begin
    rel      = tv_q - ent_y;
    height   = 8'd16 << ent_h;
    hit      = rel < {1'b0, height};
    row8     = ent_fy ? (height - 8'd1 - rel[7:0]) : rel[7:0];
    code_eff = ent_code + {13'd0, row8[6:4]};
  end

  // ROM handshake: rom_req stays high with rom_addr frozen until the single-cycle
  // rom_ack; a line_start during FETCH still waits for that ack, then drops the data.
  always_comb begin
    state_d = state_q;
    if (state_q == S_FETCH) begin
      if (rom_ack) state_d = (line_start || abort_q) ? S_ADDR : S_WAIT_LB;
    end else if (line_start) begin
      state_d = S_ADDR;
    end else begin
      case (state_q)
        S_ADDR:     state_d = S_WAIT_OBJ;
        S_WAIT_OBJ: state_d = S_CHECK;
        S_CHECK:    state_d = hit ? S_FETCH : S_NEXT;
        S_WAIT_LB:  if (lb_idle) state_d = S_WRITE;
        S_WRITE:    state_d = cap_hit ? S_DONE : S_NEXT;
        S_NEXT:     state_d = (idx_q == IW'(NUM_OBJ - 1)) ? S_DONE : S_ADDR;
        S_DONE:     state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q        <= '0;
      tv_q         <= '0;
      abort_q      <= 1'b0;
      rom_addr     <= '0;
      lb_bitplanes <= '0;
      lb_flip      <= 1'b0;
      lb_color     <= '0;
      lb_pos       <= '0;
      ent_y        <= '0;
      ent_h        <= '0;
      ent_code     <= '0;
      ent_color    <= '0;
      ent_fx       <= 1'b0;
      ent_fy       <= 1'b0;
      ent_x        <= '0;
    end else begin
      if (line_start) begin
        tv_q    <= target_v;
        idx_q   <= '0;
        abort_q <= (state_q == S_FETCH) && !rom_ack;
      end else begin
        if (state_q == S_FETCH && rom_ack) abort_q <= 1'b0;
        if (state_q == S_NEXT) idx_q <= idx_q + 1'b1;
      end
      if (state_q == S_WAIT_OBJ) begin
        ent_y     <= obj_data[8:0];
        ent_h     <= obj_data[10:9];
        ent_code  <= obj_data[31:16];
        ent_color <= obj_data[35:32];
        ent_fx    <= obj_data[36];
        ent_fy    <= obj_data[37];
        ent_x     <= obj_data[57:48];
      end
      if (state_q == S_CHECK) rom_addr <= {code_eff, row8[3:0]};
      if (state_q == S_FETCH && rom_ack && !line_start && !abort_q) begin
        lb_bitplanes <= rom_data;
        lb_flip      <= ent_fx;
        lb_color     <= ent_color;
        lb_pos       <= ent_x;
      end
    end
  end

  assign obj_addr  = 8'(idx_q);
  assign rom_req   = (state_q == S_FETCH);
  // a restart landing on the WRITE cycle cancels the strobe
  assign lb_we     = (state_q == S_WRITE) && !line_start;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign dbg_state = state_q;

`ifdef SPRITE_LIMIT_EN
  localparam int CW = $clog2(MAX_PER_LINE + 1);
  logic [CW-1:0] hit_cnt_q;
  logic          ovf_q;

  assign cap_hit = (hit_cnt_q == CW'(MAX_PER_LINE - 1));

  always_ff @(posedge clk) begin
    if (reset || line_start) begin
      hit_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else if (lb_we) begin
      hit_cnt_q <= hit_cnt_q + 1'b1;
      if (cap_hit) ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`else
  logic unused_cap;
  assign cap_hit    = 1'b0;
  assign overflow   = 1'b0;
  assign unused_cap = (MAX_PER_LINE == 0);
`endif

  logic unused_bits;
  assign unused_bits = ^{obj_data[15:11], obj_data[47:38], obj_data[63:58], row8[7]};

endmodule

// File: tb/tb_sprite_line_sched.sv
// Directed bench for sprite_line_sched: object RAM model, ROM responder, draw-command scoreboard.
module tb_sprite_line_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [8:0]  target_v;
  logic [7:0]  obj_addr;
  logic [63:0] obj_data;
  logic        rom_req;
  logic [19:0] rom_addr;
  logic        rom_ack = 1'b0;
  logic [63:0] rom_data = '0;
  logic [63:0] lb_bitplanes;
  logic        lb_flip;
  logic [3:0]  lb_color;
  logic [9:0]  lb_pos;
  logic        lb_we;
  logic        lb_idle;
  logic        busy;
  logic        overflow;
  logic [3:0]  dbg_state;

`ifdef SPRITE_LIMIT_EN
  localparam int EXP_N   = 32;
  localparam bit EXP_OVF = 1'b1;
`else
  localparam int EXP_N   = 40;
  localparam bit EXP_OVF = 1'b0;
`endif

  sprite_line_sched #(.NUM_OBJ(128), .MAX_PER_LINE(32)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .target_v(target_v),
    .obj_addr(obj_addr), .obj_data(obj_data),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .lb_bitplanes(lb_bitplanes), .lb_flip(lb_flip), .lb_color(lb_color), .lb_pos(lb_pos),
    .lb_we(lb_we), .lb_idle(lb_idle), .busy(busy), .overflow(overflow), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int n_wr, n_ack, req_cycles, rom_delay, rcnt, cyc;
  logic [78:0] exp_q[$];
  logic [19:0] rom_q[$];
  logic [63:0] obj_mem [0:127];
  logic        req_prev = 1'b0;
  logic [19:0] addr_prev = '0;
  logic        idle_s = 1'b0;
  logic [78:0] exp_cmd;

  function automatic logic [63:0] ent(input logic [8:0] y, input logic [1:0] h,
                                      input logic [15:0] code, input logic [3:0] color,
                                      input logic fx, input logic fy, input logic [9:0] x);
    logic [63:0] e;
    e = 64'h0;
    e[15:11] = 5'h15;
    e[47:38] = 10'h2AA;
    e[63:58] = 6'h2A;
    e[8:0] = y; e[10:9] = h; e[31:16] = code; e[35:32] = color;
    e[36] = fx; e[37] = fy; e[57:48] = x;
    return e;
  endfunction

  function automatic logic [63:0] rom_word(input logic [19:0] a);
    return {a, 24'hA5C3E1, a};
  endfunction

  function automatic logic [78:0] cmd(input logic [9:0] x, input logic [3:0] c,
                                      input logic f, input logic [63:0] bp);
    return {x, c, f, bp};
  endfunction

  function automatic logic [19:0] rom_at(input int i);
    return (rom_q.size() > i) ? rom_q[i] : 20'hxxxxx;
  endfunction

  // object RAM: one cycle of read latency
  always @(posedge clk) obj_data <= obj_mem[obj_addr[6:0]];

  // ROM responder: acks after rom_delay extra cycles of request
  always @(posedge clk) begin
    #1;
    if (rom_req && !rom_ack) begin
      if (rcnt >= rom_delay) begin
        rom_ack  = 1'b1;
        rom_data = rom_word(rom_addr);
        rcnt     = 0;
      end else begin
        rcnt++;
      end
    end else begin
      rom_ack = 1'b0;
      rcnt    = 0;
    end
  end

  always @(posedge clk) idle_s <= lb_idle;

  // monitor + scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (rom_req) req_cycles++;
      if (rom_req && req_prev) begin
        n_cmp++;
        assert (rom_addr === addr_prev) else begin
          n_err++; $error("FAIL rom_addr_stable: observed %h expected %h", rom_addr, addr_prev);
        end
      end
      if (rom_ack) begin rom_q.push_back(rom_addr); n_ack++; end
      if (lb_we) begin
        n_wr++;
        n_cmp++;
        assert (idle_s === 1'b1) else begin
          n_err++; $error("FAIL we_after_idle: observed idle %b expected 1", idle_s);
        end
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++; $error("FAIL lb_unexpected: observed pos %0d expected no write", lb_pos);
        end
        if (exp_q.size() != 0) begin
          exp_cmd = exp_q.pop_front();
          n_cmp++;
          assert ({lb_pos, lb_color, lb_flip, lb_bitplanes} === exp_cmd) else begin
            n_err++; $error("FAIL lb_cmd: observed %h expected %h",
                            {lb_pos, lb_color, lb_flip, lb_bitplanes}, exp_cmd);
          end
        end
      end
    end
    req_prev  = rom_req;
    addr_prev = rom_addr;
  end

  // driver tasks
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++; $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic fill_filler();
    for (int i = 0; i < 128; i++) obj_mem[i] = ent(9'd300, 2'd0, 16'h0, 4'h0, 1'b0, 1'b0, 10'd0);
  endtask

  task automatic clear_logs();
    n_wr = 0; n_ack = 0; req_cycles = 0;
    rom_q.delete();
    exp_q.delete();
  endtask

  task automatic start_line(input logic [8:0] tv);
    @(posedge clk); #1;
    target_v = tv; line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int c);
    c = 0;
    @(negedge clk);
    while (busy && c < budget) begin c++; @(negedge clk); end
    check("done_timeout", busy, 0);
  endtask

  task automatic wait_req(input int budget);
    int c = 0;
    @(negedge clk);
    while (!rom_req && c < budget) begin c++; @(negedge clk); end
    check("req_timeout", rom_req, 1);
  endtask

  task automatic wait_ack(input int budget);
    int c = 0;
    @(negedge clk);
    while (!rom_ack && c < budget) begin c++; @(negedge clk); end
    check("ack_timeout", rom_ack, 1);
  endtask

  logic [63:0] spr_a, spr_b;

  initial begin
    reset = 1'b1; line_start = 1'b0; target_v = '0; lb_idle = 1'b1;
    rom_delay = 2; rcnt = 0;
    clear_logs();
    fill_filler();
    spr_a = ent(9'd100, 2'd0, 16'h0123, 4'd3, 1'b0, 1'b0, 10'd40);
    spr_b = ent(9'd500, 2'd1, 16'h0010, 4'hA, 1'b1, 1'b1, 10'd7);

    // reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rom_req", rom_req, 0);
    check("rst_lb_we", lb_we, 0);
    check("rst_overflow", overflow, 0);
    check("rst_state", dbg_state, 0);
    check("rst_obj_addr", obj_addr, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_lb_bitplanes", lb_bitplanes, 0);
    check("rst_lb_pos", lb_pos, 0);

    // single sprite at entry 5
    clear_logs();
    obj_mem[5] = spr_a;
    exp_q.push_back(cmd(10'd40, 4'd3, 1'b0, rom_word(20'h01237)));
    start_line(9'd107);
    wait_done(2000, cyc);
    check("t1_busy_cycles", cyc, 517);
    check("t1_acks", n_ack, 1);
    check("t1_rom_addr", rom_at(0), 20'h01237);
    check("t1_writes", n_wr, 1);
    check("t1_exp_left", exp_q.size(), 0);

    // tall, flipped, wrapping across line 0
    clear_logs();
    obj_mem[5] = ent(9'd300, 2'd0, 16'h0, 4'h0, 1'b0, 1'b0, 10'd0);
    obj_mem[9] = spr_b;
    exp_q.push_back(cmd(10'd7, 4'hA, 1'b1, rom_word(20'h00109)));
    start_line(9'd10);
    wait_done(2000, cyc);
    check("t2_acks", n_ack, 1);
    check("t2_rom_addr", rom_at(0), 20'h00109);
    check("t2_writes", n_wr, 1);
    check("t2_exp_left", exp_q.size(), 0);

    clear_logs();
    start_line(9'd468);
    wait_done(2000, cyc);
    check("t2_miss_acks", n_ack, 0);
    check("t2_miss_writes", n_wr, 0);

    // 128-high sprite at y=0, code wraps when the row block is added
    clear_logs();
    obj_mem[9]  = ent(9'd300, 2'd0, 16'h0, 4'h0, 1'b0, 1'b0, 10'd0);
    obj_mem[20] = ent(9'd0, 2'd3, 16'hFFFE, 4'hF, 1'b0, 1'b0, 10'd1023);
    exp_q.push_back(cmd(10'd1023, 4'hF, 1'b0, rom_word(20'h00044)));
    start_line(9'd100);
    wait_done(2000, cyc);
    check("t3_rom_addr", rom_at(0), 20'h00044);
    check("t3_writes", n_wr, 1);
    check("t3_exp_left", exp_q.size(), 0);

    // slow ROM and busy line buffer
    clear_logs();
    obj_mem[20] = ent(9'd300, 2'd0, 16'h0, 4'h0, 1'b0, 1'b0, 10'd0);
    obj_mem[5]  = spr_a;
    rom_delay = 20;
    @(posedge clk); #1 lb_idle = 1'b0;
    exp_q.push_back(cmd(10'd40, 4'd3, 1'b0, rom_word(20'h01237)));
    start_line(9'd107);
    wait_ack(200);
    repeat (30) @(posedge clk);
    #1;
    check("t4_no_we_while_busy_lb", n_wr, 0);
    lb_idle = 1'b1;
    @(negedge clk);
    check("t4_we_not_same_cycle", lb_we, 0);
    @(negedge clk);
    check("t4_we_next_cycle", lb_we, 1);
    wait_done(2000, cyc);
    check("t4_req_cycles", req_cycles, 21);
    check("t4_writes", n_wr, 1);
    check("t4_exp_left", exp_q.size(), 0);

    // restart during FETCH: first fetch discarded, scan restarts with new line
    clear_logs();
    rom_delay = 5;
    obj_mem[9] = spr_b;
    exp_q.push_back(cmd(10'd7, 4'hA, 1'b1, rom_word(20'h00109)));
    start_line(9'd107);
    wait_req(200);
    start_line(9'd10);
    wait_done(3000, cyc);
    check("t5_acks", n_ack, 2);
    check("t5_rom_addr0", rom_at(0), 20'h01237);
    check("t5_rom_addr1", rom_at(1), 20'h00109);
    check("t5_writes", n_wr, 1);
    check("t5_exp_left", exp_q.size(), 0);

    // 40 hits on one line
    clear_logs();
    fill_filler();
    rom_delay = 0;
    for (int i = 0; i < 40; i++) begin
      obj_mem[i] = ent(9'd195, 2'd0, 16'(i), 4'(i), 1'b0, 1'b0, 10'(i));
      if (i < EXP_N) exp_q.push_back(cmd(10'(i), 4'(i), 1'b0, rom_word({16'(i), 4'd5})));
    end
    start_line(9'd200);
    wait_done(5000, cyc);
    check("t6_writes", n_wr, EXP_N);
    check("t6_exp_left", exp_q.size(), 0);
    check("t6_overflow", overflow, EXP_OVF);
    clear_logs();
    start_line(9'd10);
    @(negedge clk);
    check("t6_overflow_cleared", overflow, 0);
    wait_done(2000, cyc);
    check("t6_next_line_writes", n_wr, 0);

    // reset in the middle of a fetch
    clear_logs();
    fill_filler();
    obj_mem[5] = spr_a;
    rom_delay = 1000;
    start_line(9'd107);
    wait_req(200);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t7_rom_req", rom_req, 0);
    check("t7_busy", busy, 0);
    check("t7_state", dbg_state, 0);
    check("t7_lb_we", lb_we, 0);
    check("t7_obj_addr", obj_addr, 0);
    rom_delay = 2;
    clear_logs();
    exp_q.push_back(cmd(10'd40, 4'd3, 1'b0, rom_word(20'h01237)));
    start_line(9'd107);
    wait_done(2000, cyc);
    check("t7_acks", n_ack, 1);
    check("t7_writes", n_wr, 1);
    check("t7_exp_left", exp_q.size(), 0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_line_sched.md
Name: sprite_line_sched

Overview:
- Per-scanline sprite scheduler that feeds a double line buffer.
- Walks the object attribute RAM for the next display line and selects the sprites that intersect it.
- Fetches one 16-pixel tile row per hit from graphics ROM over a req/ack handshake.
- Issues one draw command per hit to the line buffer, honouring the buffer's idle flag.
- Sits between object RAM, the SDRAM/ROM arbiter and the line buffer draw port.

Parameters:
- NUM_OBJ, 128: object entries scanned per line (power of two, 2..256).
- MAX_PER_LINE, 32: sprite-per-line cap; used only when SPRITE_LIMIT_EN is defined.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- line_start  in  1  one-cycle pulse: begin scheduling for line target_v
- target_v  in  9  line being prepared, sampled on line_start
- obj_addr  out  8  object RAM address (low log2(NUM_OBJ) bits used)
- obj_data  in  64  object entry, valid exactly 1 cycle after obj_addr changes
- rom_req  out  1  tile-row fetch request
- rom_addr  out  20  {code_eff[15:0], row[3:0]}
- rom_ack  in  1  one-cycle pulse; rom_data valid in the same cycle
- rom_data  in  64  raw bitplanes for one 16-pixel row
- lb_bitplanes  out  64  to line buffer
- lb_flip  out  1  horizontal flip
- lb_color  out  4  palette bank
- lb_pos  out  10  sprite x
- lb_we  out  1  one-cycle draw strobe
- lb_idle  in  1  line buffer ready for a command
- busy  out  1  high from line_start until DONE
- overflow  out  1  set when the cap truncated the current line

Behaviour:
- Entry fields:
  - [8:0] y
  - [10:9] h: height = 16<<h, giving 16/32/64/128
  - [31:16] code
  - [35:32] color
  - [36] flipx
  - [37] flipy
  - [57:48] x
  - all other bits ignored
- Hit test: rel = (target_v - y) mod 512 (9-bit wrap). Hit iff rel < (16<<h). An entry with y=0 is a valid sprite; there is no disable bit.
- row = flipy ? (16<<h)-1-rel : rel.
- code_eff = code + row[6:4] (16-bit, wraps).
- States:
  - IDLE: wait for line_start.
  - ADDR: drive obj_addr = idx.
  - WAIT_OBJ: 1 cycle for RAM latency.
  - CHECK: evaluate hit. Miss → NEXT. Hit → FETCH.
  - FETCH: rom_req=1, rom_addr stable until rom_ack. On ack, latch rom_data, flipx, color, x → WAIT_LB.
  - WAIT_LB: wait for lb_idle=1 → WRITE.
  - WRITE: lb_we=1 for exactly one cycle with latched values → NEXT.
  - NEXT: idx+1. Past NUM_OBJ-1 → DONE, else ADDR.
  - DONE: busy=0 → IDLE.
- Entry order: ascending 0..NUM_OBJ-1. Later entries draw over earlier ones, because the line buffer overwrites.
- Best-case per entry: miss = 4 cycles. Hit = 6 cycles + ROM latency + idle wait.
- lb_we must never assert unless lb_idle was sampled high in the preceding cycle.
- line_start while busy:
  - Latch the new target_v, set idx=0, clear overflow and the hit counter.
  - If in FETCH, keep rom_req high until rom_ack, discard that data, then go to ADDR.
  - Otherwise go to ADDR next cycle.
  - A pending write in WAIT_LB/WRITE is discarded.
- rom_ack outside FETCH is ignored.
- Reset (any state):
  - Registers/state: state=IDLE, idx=0, lb_we=0, rom_req=0, busy=0, overflow=0.
  - Data outputs: lb_bitplanes=0, lb_pos=0, lb_color=0, lb_flip=0, rom_addr=0, obj_addr=0.
  - An in-flight ROM request is abandoned; the arbiter must tolerate a dropped req.

Optional Feature:
- Macro SPRITE_LIMIT_EN.
- Defined: a hit counter increments on each WRITE. When it reaches MAX_PER_LINE, go to DONE immediately and set overflow=1. overflow holds until the next line_start or reset.
- Undefined: no cap, all hits are drawn, and overflow is tied to 0.

Test Plan:
- Single sprite: entry 5 has y=100, h=0, code=0x0123, x=40, color=3, flipx=0; line_start with target_v=107 → one rom_req with rom_addr=0x01237, then one lb_we with lb_pos=40, lb_color=3, lb_flip=0. busy drops after entry NUM_OBJ-1.
- Tall, flipped, wrapping: y=500, h=1, flipy=1, code=0x0010, target_v=10 → rel=22, row=9, rom_addr=0x00109. Same entry with target_v=468 → no request.
- Handshake: hold rom_ack off for 20 cycles → rom_addr stable and rom_req high throughout. Hold lb_idle low for 30 cycles after ack → no lb_we until 1 cycle after idle rises.
- Abort: line_start arrives during FETCH → request completes, its data is never written, and the scan restarts at entry 0 with the new target_v.
- Cap: with SPRITE_LIMIT_EN and MAX_PER_LINE=32, 40 hitting entries → exactly 32 lb_we pulses (entries 0..31) and overflow=1. Without the macro → 40 pulses and overflow=0.
- Reset mid-FETCH → next cycle rom_req=0, busy=0, state IDLE. A following line_start schedules normally.
